// File: rtl/scrypt_nonce_sequencer.sv
// Feeds header+nonce words to the scrypt core over a nonce range and reports the first match or exhaustion.
// Optional watchdog on the core wait is built when SCRYPT_SEQ_WATCHDOG_EN is defined.
module scrypt_nonce_sequencer #(
  parameter int ISSUE_GAP = 1,
  parameter int WD_CYCLES = 2097152
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         wr_en,
  input  logic [31:0]  wr_data,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic [639:0] core_data,
  output logic         core_enable,
  input  logic         core_done,
  input  logic         core_match,
  output logic         busy,
  output logic         hdr_valid,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic         exhausted,
  output logic         timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t      state, state_nxt;
  logic [31:0] hdr_word [19];
  logic [4:0]  wr_ptr;
  logic [31:0] nonce, nonce_last;
  logic [3:0]  gap_cnt;
  logic        wr_accept;
  logic        accept_start, set_found, set_exhausted, step_nonce, set_timeout;
  logic        wd_expired;

  if (ISSUE_GAP < 0 || ISSUE_GAP > 15) begin : g_bad_gap
    $error("ISSUE_GAP must be within 0..15");
  end
  if (WD_CYCLES < 1) begin : g_bad_wd
    $error("WD_CYCLES must be at least 1");
  end

  assign busy        = (state != IDLE);
  assign core_enable = (state == ISSUE);
  assign wr_accept   = wr_en && !busy;

  // Word 0 sits in the most significant slot, nonce in the least.
  for (genvar k = 0; k < 19; k++) begin : g_pack
    assign core_data[639-32*k -: 32] = hdr_word[k];
  end
  assign core_data[31:0] = nonce;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    accept_start  = 1'b0;
    set_found     = 1'b0;
    set_exhausted = 1'b0;
    step_nonce    = 1'b0;
    set_timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (start && hdr_valid) begin
          accept_start = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: state_nxt = abort ? IDLE : WAIT;
      WAIT: begin
        // Abort outranks a same-cycle done so the core result is dropped.
        if (abort) begin
          state_nxt = IDLE;
        end else if (core_done) begin
          if (core_match) begin
            set_found = 1'b1;
            state_nxt = IDLE;
          end else if (nonce == nonce_last) begin
            set_exhausted = 1'b1;
            state_nxt     = IDLE;
          end else begin
            step_nonce = 1'b1;
            state_nxt  = (ISSUE_GAP == 0) ? ISSUE : GAP;
          end
        end else if (wd_expired) begin
          set_timeout = 1'b1;
          state_nxt   = IDLE;
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (gap_cnt == 4'(ISSUE_GAP - 1)) begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gap_cnt <= '0;
    end else if (state != GAP) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < 19; k++) hdr_word[k] <= '0;
      wr_ptr    <= '0;
      hdr_valid <= 1'b0;
    end else if (wr_accept) begin
      hdr_word[wr_ptr] <= wr_data;
      if (wr_ptr == 5'd18) begin
        wr_ptr    <= '0;
        hdr_valid <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + 5'd1;
        if (wr_ptr == 5'd0) hdr_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      nonce       <= '0;
      nonce_last  <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
      exhausted   <= 1'b0;
    end else begin
      if (accept_start) begin
        nonce       <= nonce_start;
        nonce_last  <= nonce_end;
        found       <= 1'b0;
        found_nonce <= '0;
        exhausted   <= 1'b0;
      end
      if (step_nonce) nonce <= nonce + 32'd1;
      if (set_found) begin
        found       <= 1'b1;
        found_nonce <= nonce;
      end
      if (set_exhausted) exhausted <= 1'b1;
    end
  end

`ifdef SCRYPT_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside WAIT, so every entry into WAIT starts a fresh count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt <= '0;
    end else if (state != WAIT) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expired = (state == WAIT) && (wd_cnt == WD_W'(WD_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timeout <= 1'b0;
    end else if (accept_start) begin
      timeout <= 1'b0;
    end else if (set_timeout) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_scrypt_nonce_sequencer.sv
// Scoreboard bench: stimulus queues expected issues/results, monitors pop and compare.
module tb_scrypt_nonce_sequencer;

  typedef struct packed {
    logic [31:0] nonce;
    logic        first;
  } issue_t;

  typedef struct packed {
    logic        found;
    logic        exhausted;
    logic        timeout;
    logic [31:0] fnonce;
  } result_t;

  logic         clk = 1'b0;
  logic         n_rst, wr_en, start, abort, core_done, core_match;
  logic [31:0]  wr_data, nonce_start, nonce_end, found_nonce;
  logic [639:0] core_data;
  logic         core_enable, busy, hdr_valid, found, exhausted, timeout;

  int checks = 0, fails = 0;
  int cyc = 0, start_cyc = 0, last_en_cyc = 0, en_cyc = 0, fall_cyc = 0;
  logic [31:0] hdr_exp [19];
  issue_t  exp_issue [$];
  result_t exp_res [$];
  issue_t  cur_issue;
  result_t cur_res;
  bit          hang = 0, abort_on_done = 0, match_en = 0;
  logic [31:0] match_nonce = '0;
  logic [31:0] core_cur = '0;
  int          dly = 0;
  logic        prev_busy = 1'b0;

  scrypt_nonce_sequencer #(.ISSUE_GAP(1), .WD_CYCLES(64)) dut (
    .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_data(wr_data),
    .start(start), .abort(abort), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .core_data(core_data), .core_enable(core_enable), .core_done(core_done),
    .core_match(core_match), .busy(busy), .hdr_valid(hdr_valid), .found(found),
    .found_nonce(found_nonce), .exhausted(exhausted), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [607:0] hdr_pack();
    logic [607:0] r;
    for (int k = 0; k < 19; k++) r[607-32*k -: 32] = hdr_exp[k];
    return r;
  endfunction

  // Core model: done two cycles after each enable, match against a chosen nonce.
  initial begin
    core_done = 1'b0; core_match = 1'b0; abort = 1'b0;
    forever begin
      @(negedge clk);
      core_done = 1'b0; core_match = 1'b0; abort = 1'b0;
      if (core_enable && !hang) begin
        core_cur = core_data[31:0];
        dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          core_done  = 1'b1;
          core_match = match_en && (core_cur == match_nonce);
          abort      = abort_on_done;
        end
      end
    end
  end

  // Issue monitor.
  always @(negedge clk) begin
    if (n_rst && core_enable) begin
      if (exp_issue.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_issue: nonce %0h issued, no issue expected", core_data[31:0]);
      end else begin
        cur_issue = exp_issue.pop_front();
        chk("issue_nonce", core_data[31:0], cur_issue.nonce);
        chk("issue_hdr", core_data[639:32], hdr_pack());
        if (cur_issue.first) chk("start_latency", cyc - start_cyc, 1);
        else                 chk("issue_spacing", cyc - last_en_cyc, 4);
      end
      last_en_cyc = cyc;
      en_cyc      = cyc;
    end
  end

  // Result monitor: compares sticky flags when busy drops.
  always @(negedge clk) begin
    if (n_rst && prev_busy && !busy) begin
      fall_cyc = cyc;
      if (exp_res.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_result: found=%0b exhausted=%0b, no result expected", found, exhausted);
      end else begin
        cur_res = exp_res.pop_front();
        chk("res_found", found, cur_res.found);
        chk("res_exhausted", exhausted, cur_res.exhausted);
        chk("res_timeout", timeout, cur_res.timeout);
        chk("res_found_nonce", found_nonce, cur_res.fnonce);
      end
    end
    prev_busy = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input logic [31:0] d);
    @(negedge clk); wr_en = 1'b1; wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic push_range(input logic [31:0] s, input int count);
    issue_t it;
    for (int i = 0; i < count; i++) begin
      it.nonce = s + 32'(i);
      it.first = (i == 0);
      exp_issue.push_back(it);
    end
  endtask

  task automatic push_res(input logic f, input logic e, input logic t, input logic [31:0] n);
    result_t r;
    r.found = f; r.exhausted = e; r.timeout = t; r.fnonce = n;
    exp_res.push_back(r);
  endtask

  task automatic sweep(input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    nonce_start = s; nonce_end = e; start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_bound", busy, 1'b0);
    tick(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0;
    nonce_start = '0; nonce_end = '0;
    for (int k = 0; k < 19; k++) hdr_exp[k] = '0;
    tick(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hdr_valid", hdr_valid, 1'b0);
    chk("rst_found", found, 1'b0);
    chk("rst_exhausted", exhausted, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_core_enable", core_enable, 1'b0);
    chk("rst_core_data", core_data, '0);
    chk("rst_found_nonce", found_nonce, '0);
    n_rst = 1'b1;
    tick(1);

    // start without a loaded header is ignored
    @(negedge clk); start = 1'b1; nonce_start = 32'h5; nonce_end = 32'h5;
    @(negedge clk); start = 1'b0;
    tick(1);
    chk("start_no_hdr", busy, 1'b0);

    for (int k = 0; k < 19; k++) begin
      hdr_exp[k] = 32'(k);
      write_word(32'(k));
      if (k == 17) chk("hdr_valid_before_last", hdr_valid, 1'b0);
    end
    chk("hdr_valid_loaded", hdr_valid, 1'b1);
    chk("hdr_word0", core_data[639:608], 32'h0);
    chk("hdr_word18", core_data[63:32], 32'h12);

    push_range(32'h10, 3);
    push_res(1'b0, 1'b1, 1'b0, 32'h0);
    sweep(32'h10, 32'h12);
    wait_idle(100);

    match_en = 1; match_nonce = 32'h105;
    push_range(32'h100, 6);
    push_res(1'b1, 1'b0, 1'b0, 32'h105);
    sweep(32'h100, 32'h1FF);
    wait_idle(200);
    tick(10);
    match_en = 0;

    push_range(32'hFFFF_FFFE, 4);
    push_res(1'b0, 1'b1, 1'b0, 32'h0);
    sweep(32'hFFFF_FFFE, 32'h0000_0001);
    wait_idle(200);

    push_range(32'h7, 1);
    push_res(1'b0, 1'b1, 1'b0, 32'h0);
    sweep(32'h7, 32'h7);
    wait_idle(100);

    // abort lands with a matching done; start and wr_en while busy are dropped
    abort_on_done = 1; match_en = 1; match_nonce = 32'h20;
    push_range(32'h20, 1);
    push_res(1'b0, 1'b0, 1'b0, 32'h0);
    sweep(32'h20, 32'h30);
    @(negedge clk);
    start = 1'b1; nonce_start = 32'h99; nonce_end = 32'h99;
    wr_en = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_idle(100);
    abort_on_done = 0; match_en = 0;
    chk("hdr_valid_after_busy_write", hdr_valid, 1'b1);

    push_range(32'h40, 1);
    push_res(1'b0, 1'b1, 1'b0, 32'h0);
    sweep(32'h40, 32'h40);
    wait_idle(100);

    hdr_exp[0] = 32'hAAAA_5555;
    write_word(32'hAAAA_5555);
    chk("reload_clears_valid", hdr_valid, 1'b0);
    for (int k = 1; k < 19; k++) begin
      hdr_exp[k] = 32'h100 + 32'(k);
      write_word(hdr_exp[k]);
    end
    chk("reload_valid", hdr_valid, 1'b1);
    push_range(32'h60, 2);
    push_res(1'b0, 1'b1, 1'b0, 32'h0);
    sweep(32'h60, 32'h61);
    wait_idle(100);

`ifdef SCRYPT_SEQ_WATCHDOG_EN
    hang = 1;
    push_range(32'h80, 1);
    push_res(1'b0, 1'b0, 1'b1, 32'h0);
    sweep(32'h80, 32'h90);
    wait_idle(300);
    chk("wd_latency", fall_cyc - en_cyc, 65);
    hang = 0;
`endif

    tick(5);
    chk("issues_drained", exp_issue.size(), 0);
    chk("results_drained", exp_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/scrypt_nonce_sequencer.md
Name: scrypt_nonce_sequencer

Overview:
Work feeder directly upstream of the scrypt hashing top level.
- Accepts a 76-byte block header as 19 words over a 32-bit write port.
- Sweeps a nonce range and presents each 640-bit header+nonce word to the core with a one-cycle enable.
- Waits for the core's done, samples its match flag, and reports the first matching nonce or range exhaustion.

Parameters:
ISSUE_GAP, 1, idle cycles between core_done and the next core_enable (legal range 0..15).
WD_CYCLES, 2097152, watchdog limit in clk cycles while waiting on the core (used only with the optional feature).

Ports:
clk  in  1  clock
n_rst  in  1  reset
wr_en  in  1  header word write strobe
wr_data  in  32  header word
start  in  1  begin sweep (single-cycle pulse)
abort  in  1  stop sweep
nonce_start  in  32  first nonce, sampled on accepted start
nonce_end  in  32  last nonce inclusive, sampled on accepted start
core_data  out  640  header+nonce to core
core_enable  out  1  one-cycle launch pulse
core_done  in  1  core finished current hash
core_match  in  1  core hash met target, valid with core_done
busy  out  1  sweep in progress
hdr_valid  out  1  all 19 header words loaded
found  out  1  sticky: match found
found_nonce  out  32  nonce that matched
exhausted  out  1  sticky: range finished without match
timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset: n_rst, asynchronous, active-low; clock clk. All outputs, header store, wr_ptr, nonce counter and state reset to 0. State resets to IDLE.
- Header load:
  - wr_en writes wr_data into word[wr_ptr], then wr_ptr increments.
  - Write at wr_ptr=18 sets hdr_valid; wr_ptr wraps to 0.
  - A write at wr_ptr=0 while hdr_valid=1 clears hdr_valid (reload begins).
  - wr_en while busy=1 is ignored; wr_ptr is unchanged.
- core_data layout:
  - word0 at [639:608], word k at [639-32k -: 32], word18 at [63:32].
  - Current nonce at [31:0].
  - Held stable from the ISSUE cycle until core_done is sampled.
- start is accepted only in IDLE with hdr_valid=1. Otherwise it is ignored.
- Accepted start:
  - Clears found, exhausted, timeout and found_nonce.
  - Loads nonce=nonce_start and latches end=nonce_end.
  - Sets busy.
- States:
  - IDLE: start accepted -> ISSUE.
  - ISSUE: core_enable=1 for exactly this cycle -> WAIT.
  - WAIT: core_done=1 -> evaluate:
    - core_match=1 -> found=1, found_nonce=nonce -> IDLE.
    - else nonce==end -> exhausted=1 -> IDLE.
    - else nonce<=nonce+1 (mod 2^32) -> GAP.
  - GAP: wait ISSUE_GAP cycles (0 = skip directly to ISSUE) -> ISSUE.
- Latency:
  - start at cycle t -> core_enable at t+1.
  - core_done at cycle d (no match, not end) -> next core_enable at d+1+ISSUE_GAP.
- Boundary conditions:
  - nonce_start==nonce_end: exactly one hash.
  - nonce_start>nonce_end: sweep wraps 0xFFFFFFFF->0x00000000 and continues to end.
  - Full range (start=end+1) covers all 2^32 nonces.
- core_done outside WAIT is ignored. core_match without core_done is ignored.
- abort while busy: next state IDLE; busy drops next cycle; found and exhausted stay 0.
  - abort in the same cycle as core_done: abort wins and the result is discarded.
  - abort in IDLE: no effect.
- start while busy: ignored.
- busy=1 in every state except IDLE. busy falls in the same cycle found or exhausted rises.
- Reset mid-sweep: immediate return to IDLE with all outputs 0. The header must be reloaded.

Optional Feature:
Macro SCRYPT_SEQ_WATCHDOG_EN.
- Defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - Reaching WD_CYCLES without core_done sets timeout=1 and returns to IDLE; found and exhausted stay 0.
- Not defined:
  - No counter is built.
  - timeout is tied to 0.
  - WAIT holds indefinitely.

Test Plan:
- Load 19 words 0x00000000..0x00000012 -> hdr_valid=1 after the 19th write; core_data[639:608]=0x0, [63:32]=0x12.
- start, nonce_start=0x10, nonce_end=0x12; core returns done, no match, for each nonce -> core_enable pulses with core_data[31:0]=0x10,0x11,0x12; exhausted=1, busy=0, found=0.
- start 0x100..0x1FF; core_match=1 on nonce 0x105 -> found=1, found_nonce=0x105, no further core_enable.
- start 0xFFFFFFFE..0x00000001, no matches -> nonces FFFFFFFE, FFFFFFFF, 0, 1 issued; exhausted=1.
- abort asserted in the same cycle as core_done with core_match=1 -> IDLE, found=0; start while busy and wr_en while busy both ignored.
- With SCRYPT_SEQ_WATCHDOG_EN, WD_CYCLES=64, core never signals done -> timeout=1 at 64 cycles after entering WAIT, busy=0.
